// File: rtl/synth_audio_pkg.sv
// Shared audio-path definitions for the synthesiser output stage.
//   AUDIO_SAMPLE_W : default sample / I2S slot width
//   BCLK_HALF_48K  : Clk cycles per BCLK half-period (50 MHz -> ~48.8 kHz frames)
//   audio_sample_t : signed two's-complement audio sample
//   slot_is_right  : LRCK level for a given slot index
package synth_audio_pkg;

    localparam int unsigned AUDIO_SAMPLE_W = 16;
    localparam int unsigned BCLK_HALF_48K  = 16;

    typedef logic signed [AUDIO_SAMPLE_W-1:0] audio_sample_t;

    // Upper half of the frame belongs to the right channel.
    function automatic logic slot_is_right(input int unsigned slot, input int unsigned slot_w);
        return slot >= slot_w;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock generator.
// Divides clk_i down to the bit clock: div_cnt counts 0..BCLK_HALF-1 and BCLK
// toggles at the terminal count. While rst_i is high or en_i is low the divider
// and BCLK are held at zero.
// Ports:
//   clk_i  : system clock
//   rst_i  : synchronous, active-high reset
//   en_i   : 0 holds the divider in its reset state
//   bclk_o : bit clock (registered)
//   fall_o : one-cycle strobe, high in the Clk cycle whose edge drives BCLK 1->0
module i2s_bclk_gen #(
    parameter int unsigned BCLK_HALF = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic bclk_o,
    output logic fall_o
);

    localparam int unsigned CntW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            bclk_q, bclk_d;
    logic            term;

    assign term = (div_cnt_q == CntW'(BCLK_HALF - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        bclk_d    = bclk_q;
        if (term) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    // Gated so no strobe escapes on the edge that resets the divider.
    assign fall_o = en_i && !rst_i && term && bclk_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// Mono-to-stereo I2S (Philips) master transmitter for the codec DAC.
// Accepts signed samples over valid/ready into a one-entry holding register and
// sends each one on both channels, MSB first, with the standard one-bit delay
// after LRCK changes. If no new sample is waiting at frame start the previous
// sample is repeated and underrun pulses.
// Ports:
//   Clk, Reset    : system clock, synchronous active-high reset
//   Enable        : 0 holds the serial side in reset; the handshake keeps running
//   sample_in     : signed sample, qualified by sample_valid
//   sample_ready  : holding register empty
//   frame_tick    : 1-cycle pulse when a frame is loaded (start of slot 1)
//   underrun      : 1-cycle pulse with frame_tick when nothing new was waiting
//   AUD_BCLK      : bit clock
//   AUD_DACLRCK   : 0 left, 1 right
//   AUD_DACDAT    : serial data, changes with BCLK falling
module i2s_dac_tx
    import synth_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = AUDIO_SAMPLE_W,
    parameter int unsigned BCLK_HALF = BCLK_HALF_48K
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                frame_tick,
    output logic                underrun,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT
);

    localparam int unsigned Slots = 2 * SAMPLE_W;
    localparam int unsigned SlotW = $clog2(Slots);

    logic                fall;

    logic [SlotW-1:0]    slot_q, slot_d, slot_nxt;
    logic                lrck_q, lrck_d;
    logic                dat_q, dat_d;
    logic [Slots-1:0]    shift_q, shift_d;
    logic [SAMPLE_W-1:0] last_q, last_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                tick_q, tick_d;
    logic                under_q, under_d;

    logic                accept;
    logic                load;
    logic [SAMPLE_W-1:0] load_sample;

    i2s_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk_gen (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .en_i   (Enable),
        .bclk_o (AUD_BCLK),
        .fall_o (fall)
    );

    assign sample_ready = ~hold_full_q;
    assign accept       = sample_valid && !hold_full_q;
    // The fall entering slot 1 starts a new word (one-bit I2S delay).
    assign load         = fall && (slot_q == '0);
    assign load_sample  = hold_full_q ? hold_q : last_q;
    assign slot_nxt     = (slot_q == SlotW'(Slots - 1)) ? '0 : slot_q + 1'b1;

    always_comb begin
        slot_d  = slot_q;
        lrck_d  = lrck_q;
        dat_d   = dat_q;
        shift_d = shift_q;
        last_d  = last_q;
        tick_d  = 1'b0;
        under_d = 1'b0;
        if (fall) begin
            slot_d = slot_nxt;
            lrck_d = slot_is_right(32'(slot_nxt), SAMPLE_W);
            if (load) begin
                shift_d = {load_sample, load_sample};
                last_d  = load_sample;
                tick_d  = 1'b1;
                under_d = !hold_full_q;
            end else begin
                shift_d = {shift_q[Slots-2:0], 1'b0};
            end
            dat_d = shift_d[Slots-1];
        end
    end

    // An accept can only happen while empty, so it never collides with the
    // load draining a full register; a same-cycle accept survives the load.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end else if (load && hold_full_q) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || !Enable) begin
            slot_q  <= SlotW'(Slots - 1);
            lrck_q  <= 1'b1;
            dat_q   <= 1'b0;
            shift_q <= '0;
            last_q  <= '0;
            tick_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            lrck_q  <= lrck_d;
            dat_q   <= dat_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            tick_q  <= tick_d;
            under_q <= under_d;
        end
    end

    // Holding register survives Enable=0; only Reset empties it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;
    assign frame_tick  = tick_q;
    assign underrun    = under_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
module tb_i2s_dac_tx;

    localparam int HALF = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] din;
    logic        vld;
    logic        ready;
    logic        tick;
    logic        urun;
    logic        bclk;
    logic        lrck;
    logic        dat;

    int n_total = 0;
    int n_bad   = 0;

    i2s_dac_tx #(
        .SAMPLE_W  (16),
        .BCLK_HALF (HALF)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .Enable       (en),
        .sample_in    (din),
        .sample_valid (vld),
        .sample_ready (ready),
        .frame_tick   (tick),
        .underrun     (urun),
        .AUD_BCLK     (bclk),
        .AUD_DACLRCK  (lrck),
        .AUD_DACDAT   (dat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input string tag);
        logic prev;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * HALF; i++) begin
            prev = bclk;
            step();
            if (prev && !bclk) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, " fall timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_tick(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 80 * HALF; i++) begin
            step();
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, " tick timeout"}, 32'(ok), 32'd1);
    endtask

    // Count Clk edges until the first BCLK fall after release.
    task automatic count_first_fall(output int n);
        logic prev;
        n = 0;
        for (int i = 0; i < 8 * HALF; i++) begin
            prev = bclk;
            step();
            n++;
            if (prev && !bclk) break;
        end
    endtask

    // Called anywhere inside slot 1; captures slots 1..31 then slot 0 of the
    // next frame, returning left/right words and the LRCK trace.
    task automatic read_frame(output logic [15:0] l, output logic [15:0] r,
                              output logic [31:0] lr);
        logic [31:0] bits;
        logic [31:0] lrs;
        bits = '0;
        lrs  = '0;
        for (int i = 0; i < 32; i++) begin
            bits = {bits[30:0], dat};
            lrs  = {lrs[30:0], lrck};
            if (i < 31) wait_fall("frame");
        end
        l  = bits[31:16];
        r  = bits[15:0];
        lr = lrs;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        en  = 1'b1;
        vld = 1'b0;
        din = '0;
        repeat (4) step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] d);
        din = d;
        vld = 1'b1;
        step();
        vld = 1'b0;
    endtask

    localparam logic [31:0] LrTrace = 32'h0001_FFFE;

    initial begin
        logic [15:0] l, r;
        logic [31:0] lr;
        logic        early;
        logic        ok;
        int          n;

        // 1: reset state and first-fall timing
        rst = 1'b1;
        en  = 1'b1;
        vld = 1'b0;
        din = '0;
        repeat (4) step();
        check("rst bclk", 32'(bclk), 32'd0);
        check("rst lrck", 32'(lrck), 32'd1);
        check("rst dat", 32'(dat), 32'd0);
        check("rst ready", 32'(ready), 32'd1);
        check("rst tick", 32'(tick), 32'd0);
        check("rst urun", 32'(urun), 32'd0);
        rst = 1'b0;
        count_first_fall(n);
        check("first fall", 32'(n), 32'd32);
        check("slot0 lrck", 32'(lrck), 32'd0);
        check("slot0 dat", 32'(dat), 32'd0);

        // 2: single sample, both channels
        apply_reset();
        push(16'hECEB);
        check("t2 ready full", 32'(ready), 32'd0);
        wait_tick("t2");
        check("t2 urun", 32'(urun), 32'd0);
        check("t2 ready tick", 32'(ready), 32'd1);
        step();
        check("t2 ready after", 32'(ready), 32'd1);
        check("t2 tick pulse", 32'(tick), 32'd0);
        read_frame(l, r, lr);
        check("t2 left", 32'(l), 32'h0000_ECEB);
        check("t2 right", 32'(r), 32'h0000_ECEB);
        check("t2 lrck", lr, LrTrace);

        // 3: back-to-back pushes, second waits for the frame boundary
        apply_reset();
        push(16'hECEB);
        din = 16'hDEAD;
        vld = 1'b1;
        check("t3 ready full", 32'(ready), 32'd0);
        early = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < 80 * HALF; i++) begin
            step();
            if (tick) begin
                ok = 1'b1;
                break;
            end
            if (ready) early = 1'b1;
        end
        if (!ok) check("t3 tick timeout", 32'(ok), 32'd1);
        check("t3 held", 32'(early), 32'd0);
        check("t3 ready tick", 32'(ready), 32'd1);
        step();
        din = 16'h5A5A;
        check("t3 dead held", 32'(ready), 32'd0);
        read_frame(l, r, lr);
        check("t3 f1 left", 32'(l), 32'h0000_ECEB);
        check("t3 f1 right", 32'(r), 32'h0000_ECEB);
        wait_tick("t3 f2");
        check("t3 f2 urun", 32'(urun), 32'd0);
        check("t3 f2 ready", 32'(ready), 32'd1);
        step();
        vld = 1'b0;
        check("t3 third held", 32'(ready), 32'd0);
        read_frame(l, r, lr);
        check("t3 f2 left", 32'(l), 32'h0000_DEAD);
        check("t3 f2 right", 32'(r), 32'h0000_DEAD);
        check("t3 f2 lrck", lr, LrTrace);
        wait_tick("t3 f3");
        check("t3 f3 urun", 32'(urun), 32'd0);

        // 4: underrun repeats the last sample
        apply_reset();
        push(16'h1123);
        wait_tick("t4 f1");
        check("t4 f1 urun", 32'(urun), 32'd0);
        read_frame(l, r, lr);
        check("t4 f1 left", 32'(l), 32'h0000_1123);
        wait_tick("t4 f2");
        check("t4 f2 urun", 32'(urun), 32'd1);
        step();
        check("t4 urun pulse", 32'(urun), 32'd0);
        read_frame(l, r, lr);
        check("t4 f2 left", 32'(l), 32'h0000_1123);
        check("t4 f2 right", 32'(r), 32'h0000_1123);

        // 5: Enable dropped mid-frame, pending sample survives
        apply_reset();
        push(16'hECEB);
        wait_tick("t5 f1");
        push(16'h8000);
        check("t5 ready full", 32'(ready), 32'd0);
        repeat (9) wait_fall("t5 slot");
        repeat (20) step();
        check("t5 pre bclk", 32'(bclk), 32'd1);
        check("t5 pre lrck", 32'(lrck), 32'd0);
        check("t5 pre dat", 32'(dat), 32'd1);
        en = 1'b0;
        step();
        check("t5 dis bclk", 32'(bclk), 32'd0);
        check("t5 dis lrck", 32'(lrck), 32'd1);
        check("t5 dis dat", 32'(dat), 32'd0);
        check("t5 dis ready", 32'(ready), 32'd0);
        repeat (39) step();
        en = 1'b1;
        count_first_fall(n);
        check("t5 first fall", 32'(n), 32'd32);
        wait_tick("t5 f2");
        check("t5 urun", 32'(urun), 32'd0);
        read_frame(l, r, lr);
        check("t5 left", 32'(l), 32'h0000_8000);
        check("t5 right", 32'(r), 32'h0000_8000);

        // 6: Reset mid-frame empties the holding register
        apply_reset();
        push(16'h1123);
        wait_tick("t6 f1");
        push(16'hA5A5);
        check("t6 ready full", 32'(ready), 32'd0);
        repeat (19) wait_fall("t6 slot");
        repeat (5) step();
        check("t6 pre dat", 32'(dat), 32'd1);
        check("t6 pre lrck", 32'(lrck), 32'd1);
        rst = 1'b1;
        step();
        check("t6 rst ready", 32'(ready), 32'd1);
        check("t6 rst dat", 32'(dat), 32'd0);
        check("t6 rst bclk", 32'(bclk), 32'd0);
        check("t6 rst lrck", 32'(lrck), 32'd1);
        rst = 1'b0;
        wait_tick("t6 f2");
        check("t6 urun", 32'(urun), 32'd1);
        read_frame(l, r, lr);
        check("t6 left", 32'(l), 32'h0000_0000);
        check("t6 right", 32'(r), 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
